// File: rtl/sdram_pkg.sv
// Shared SDRAM types and defaults: arbiter FSM states, bus widths and a
// constant clog2 helper used for counter and pointer sizing.
package sdram_pkg;

    localparam int SDRAM_ROW_WIDTH = 13;
    localparam int SDRAM_COL_WIDTH = 10;
    localparam int SDRAM_BA_WIDTH  = 2;
    localparam int SDRAM_D_WIDTH   = 16;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_ACCEPT,
        ARB_WAIT_DONE,
        ARB_RESP
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational circular priority pick: first requester at or after the
// round-robin pointer wins, reported as one-hot, index and an any flag.
module sdram_rr_pick #(
    parameter int N_PORTS = 4,
    parameter int PW      = 2
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [PW-1:0]      i_rr_ptr,
    output logic [N_PORTS-1:0] o_onehot,
    output logic [PW-1:0]      o_index,
    output logic               o_any
);

    logic [PW-1:0] w_pos;

    // Scan from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        o_any    = |i_req;
        w_pos    = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            w_pos = PW'((int'(i_rr_ptr) + i) % N_PORTS);
            if (i_req[w_pos]) begin
                o_onehot        = '0;
                o_onehot[w_pos] = 1'b1;
                o_index         = w_pos;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one single-transaction SDRAM controller between
// N_PORTS requesters; latches the winner, issues one start pulse, returns ack/err/rdata.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int N_PORTS        = 4,
    parameter int A_ROW_WIDTH    = SDRAM_ROW_WIDTH,
    parameter int A_COL_WIDTH    = SDRAM_COL_WIDTH,
    parameter int BA_WIDTH       = SDRAM_BA_WIDTH,
    parameter int D_WIDTH        = SDRAM_D_WIDTH,
    parameter int ACCEPT_TIMEOUT = 16,
    localparam int AW            = A_ROW_WIDTH + A_COL_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_PORTS-1:0]            i_req,
    input  logic [N_PORTS-1:0]            i_rw,
    input  logic [N_PORTS*AW-1:0]         i_addr,
    input  logic [N_PORTS*BA_WIDTH-1:0]   i_ba,
    input  logic [N_PORTS*D_WIDTH-1:0]    i_wdata,
    output logic [N_PORTS-1:0]            o_ack,
    output logic                          o_err,
    output logic [D_WIDTH-1:0]            o_rdata,
    output logic [N_PORTS-1:0]            o_grant,
    output logic                          o_ctl_initial,
    output logic                          o_ctl_rw,
    output logic [AW-1:0]                 o_ctl_addr,
    output logic [BA_WIDTH-1:0]           o_ctl_ba,
    output logic [D_WIDTH-1:0]            o_ctl_data,
    input  logic [D_WIDTH-1:0]            i_ctl_data,
    input  logic                          i_ctl_busy
);

    localparam int PW = clog2(N_PORTS);
    localparam int CW = clog2(ACCEPT_TIMEOUT) + 1;

    arb_state_t r_state;
    arb_state_t w_next_state;

    logic [PW-1:0]       r_rr_ptr;
    logic [PW-1:0]       r_win_idx;
    logic [CW-1:0]       r_timeout_cnt;
    logic [CW-1:0]       w_cnt_inc;

    logic [N_PORTS-1:0]  r_ack;
    logic                r_err;
    logic [D_WIDTH-1:0]  r_rdata;
    logic [N_PORTS-1:0]  r_grant;
    logic                r_ctl_initial;
    logic                r_ctl_rw;
    logic [AW-1:0]       r_ctl_addr;
    logic [BA_WIDTH-1:0] r_ctl_ba;
    logic [D_WIDTH-1:0]  r_ctl_data;

    logic [N_PORTS-1:0]  w_ack_d;
    logic                w_err_d;
    logic [D_WIDTH-1:0]  w_rdata_d;
    logic [N_PORTS-1:0]  w_grant_d;
    logic                w_initial_d;
    logic                w_rw_d;
    logic [AW-1:0]       w_addr_d;
    logic [BA_WIDTH-1:0] w_ba_d;
    logic [D_WIDTH-1:0]  w_data_d;
    logic [PW-1:0]       w_win_d;
    logic [PW-1:0]       w_rr_d;
    logic [CW-1:0]       w_cnt_d;

    logic [N_PORTS-1:0]  w_pick_onehot;
    logic [PW-1:0]       w_pick_index;
    logic                w_pick_any;

    sdram_rr_pick #(
        .N_PORTS (N_PORTS),
        .PW      (PW)
    ) u_rr_pick (
        .i_req    (i_req),
        .i_rr_ptr (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_index  (w_pick_index),
        .o_any    (w_pick_any)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Timeout compares the incremented count so the error ack lands exactly
    // ACCEPT_TIMEOUT cycles after the start pulse.
    always_comb begin
        w_cnt_inc    = r_timeout_cnt + 1'b1;
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any && !i_ctl_busy) begin
                    w_next_state = ARB_ISSUE;
                end
            end
            ARB_ISSUE: w_next_state = ARB_WAIT_ACCEPT;
            ARB_WAIT_ACCEPT: begin
                if (i_ctl_busy) begin
                    w_next_state = ARB_WAIT_DONE;
                end else if (w_cnt_inc == CW'(ACCEPT_TIMEOUT - 1)) begin
                    w_next_state = ARB_RESP;
                end
            end
            ARB_WAIT_DONE: begin
                if (!i_ctl_busy) begin
                    w_next_state = ARB_RESP;
                end
            end
            ARB_RESP: w_next_state = ARB_IDLE;
            default:  w_next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_ack_d     = '0;
        w_err_d     = 1'b0;
        w_rdata_d   = r_rdata;
        w_grant_d   = r_grant;
        w_initial_d = 1'b0;
        w_rw_d      = r_ctl_rw;
        w_addr_d    = r_ctl_addr;
        w_ba_d      = r_ctl_ba;
        w_data_d    = r_ctl_data;
        w_win_d     = r_win_idx;
        w_rr_d      = r_rr_ptr;
        w_cnt_d     = r_timeout_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_next_state == ARB_ISSUE) begin
                    w_grant_d   = w_pick_onehot;
                    w_initial_d = 1'b1;
                    w_win_d     = w_pick_index;
                    w_rw_d      = i_rw[w_pick_index];
                    w_addr_d    = i_addr[int'(w_pick_index)*AW +: AW];
                    w_ba_d      = i_ba[int'(w_pick_index)*BA_WIDTH +: BA_WIDTH];
                    w_data_d    = i_wdata[int'(w_pick_index)*D_WIDTH +: D_WIDTH];
                end
            end
            ARB_ISSUE: w_cnt_d = '0;
            ARB_WAIT_ACCEPT: begin
                if (!i_ctl_busy) begin
                    w_cnt_d = w_cnt_inc;
                end
                if (w_next_state == ARB_RESP) begin
                    w_ack_d = r_grant;
                    w_err_d = 1'b1;
                end
            end
            ARB_WAIT_DONE: begin
                if (w_next_state == ARB_RESP) begin
                    w_ack_d = r_grant;
                    if (!r_ctl_rw) begin
                        w_rdata_d = i_ctl_data;
                    end
                end
            end
            ARB_RESP: begin
                w_grant_d = '0;
                w_rr_d    = (r_win_idx == PW'(N_PORTS - 1)) ? '0 : r_win_idx + 1'b1;
            end
            default: w_grant_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ack         <= '0;
            r_err         <= 1'b0;
            r_rdata       <= '0;
            r_grant       <= '0;
            r_ctl_initial <= 1'b0;
            r_ctl_rw      <= 1'b0;
            r_ctl_addr    <= '0;
            r_ctl_ba      <= '0;
            r_ctl_data    <= '0;
            r_win_idx     <= '0;
            r_rr_ptr      <= '0;
            r_timeout_cnt <= '0;
        end else begin
            r_ack         <= w_ack_d;
            r_err         <= w_err_d;
            r_rdata       <= w_rdata_d;
            r_grant       <= w_grant_d;
            r_ctl_initial <= w_initial_d;
            r_ctl_rw      <= w_rw_d;
            r_ctl_addr    <= w_addr_d;
            r_ctl_ba      <= w_ba_d;
            r_ctl_data    <= w_data_d;
            r_win_idx     <= w_win_d;
            r_rr_ptr      <= w_rr_d;
            r_timeout_cnt <= w_cnt_d;
        end
    end

    assign o_ack         = r_ack;
    assign o_err         = r_err;
    assign o_rdata       = r_rdata;
    assign o_grant       = r_grant;
    assign o_ctl_initial = r_ctl_initial;
    assign o_ctl_rw      = r_ctl_rw;
    assign o_ctl_addr    = r_ctl_addr;
    assign o_ctl_ba      = r_ctl_ba;
    assign o_ctl_data    = r_ctl_data;

endmodule
